apb4_mdd_router: RTL
====================

Name: apb4_mdd_router

Overview:
- Parametrised N-channel APB4 slave router; successor of the two-way fixed-select APB split in the MDD wrapper.
- Routes one upstream APB4 port to one of NUM_SLV downstream APB4 slaves by sel_i.
- Adds transfer-safe select latching, decode-error response for out-of-range select, and a per-transfer wait-state timeout with error response.
- Sits between the SoC APB fabric and the user-IP/archinfo slave set.

Parameters:
NUM_SLV, 4, number of downstream slaves (1..32)
SEL_W, 5, width of sel_i; values >= NUM_SLV are unmapped
AW, 32, APB address width
DW, 32, APB data width (pstrb width DW/8)
TIMEOUT, 255, max access-phase wait cycles before forced error; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
sel_i  in  SEL_W  slave select, sampled at transfer setup
slv_apb_paddr_i / pprot_i / psel_i / penable_i / pwrite_i / pwdata_i / pstrb_i  in  AW/3/1/1/1/DW/DW/8  upstream APB4 request
slv_apb_pready_o  out  1  upstream ready
slv_apb_prdata_o  out  DW  upstream read data
slv_apb_pslverr_o  out  1  upstream error
mst_apb_paddr_o  out  NUM_SLV*AW  per-slave address, slice i = slave i
mst_apb_pprot_o  out  NUM_SLV*3  per-slave pprot
mst_apb_psel_o  out  NUM_SLV  per-slave psel
mst_apb_penable_o  out  NUM_SLV  per-slave penable
mst_apb_pwrite_o  out  NUM_SLV  per-slave pwrite
mst_apb_pwdata_o  out  NUM_SLV*DW  per-slave write data
mst_apb_pstrb_o  out  NUM_SLV*DW/8  per-slave strobes
mst_apb_pready_i  in  NUM_SLV  per-slave ready
mst_apb_prdata_i  in  NUM_SLV*DW  per-slave read data
mst_apb_pslverr_i  in  NUM_SLV  per-slave error
cur_sel_o  out  SEL_W  latched select of current/last transfer
tmo_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: state IDLE, sel_q=0, wait_cnt=0, cur_sel_o=0, tmo_o=0; all mst_* outputs 0; upstream pready/prdata/pslverr 0.
- FSM IDLE / ACCESS.
- IDLE: on psel_i=1 (setup phase), sel_q<=sel_i and go ACCESS. Routing that cycle uses sel_i directly, so the target sees the setup phase with zero added latency.
- ACCESS: routing uses sel_q; sel_i changes are ignored until the transfer completes.
- Completion when slv_apb_pready_o=1 in ACCESS: return to IDLE and clear wait_cnt. Back-to-back setup on the next cycle is legal.
- Routing: only slice sel of every mst_* output carries upstream values; all other slices are driven 0.
- Upstream pready/prdata/pslverr are combinational from the selected slave: zero-cycle forwarding, no added wait states.
- Unmapped select (sel >= NUM_SLV):
  - no mst psel asserted;
  - ACCESS completes in its first cycle with pready=1, pslverr=1, prdata=0.
- Timeout (TIMEOUT>0):
  - wait_cnt increments each ACCESS cycle in which the selected pready_i=0;
  - when wait_cnt==TIMEOUT with pready_i still 0, force upstream pready=1, pslverr=1, prdata=0, and pulse tmo_o;
  - return to IDLE; the slave sees psel drop on the next cycle;
  - a late pready_i from the aborted slave is ignored.
- TIMEOUT=0: wait forever; wait_cnt is held at 0.
- Slave pready and timeout in the same cycle: slave response wins; no tmo_o.
- psel_i drops in ACCESS (protocol violation): go IDLE, clear wait_cnt, no error flagged.
- pready/pslverr are only meaningful while psel_i=1; forced 0 in IDLE when psel_i=0.
- wait_cnt width: clog2(TIMEOUT+1), saturating; no wrap.
- Reset mid-transfer: immediate return to reset values; the in-flight transfer is abandoned.

Test Plan:
- NUM_SLV=4: write 0xA5A5_0001 to sel=2, slave 2 pready after 3 waits -> only psel_o[2] asserted; pwdata slice 2=0xA5A5_0001; upstream pready at 4th ACCESS cycle; pslverr=0; other slices all 0.
- Read sel=1, prdata_i[1]=0x1234_5678, zero waits -> upstream prdata=0x1234_5678 in the setup+1 cycle; cur_sel_o=1.
- sel_i switches 1->3 during ACCESS of a sel=1 transfer -> psel stays on slice 1 until completion; next transfer routes to 3.
- sel=7 (unmapped) -> no psel_o bit set; one-cycle ACCESS returns pready=1, pslverr=1, prdata=0.
- TIMEOUT=8, slave 0 never ready -> after 8 wait cycles upstream pready=1, pslverr=1, tmo_o single pulse; a later pready_i[0] has no upstream effect.
- Assert rst_n_i low mid-ACCESS -> all outputs 0 asynchronously; first post-reset transfer completes normally.

Source files
------------

// File: rtl/apb4_mdd_router.sv
// apb4_mdd_router: routes one upstream APB4 port to one of NUM_SLV downstream
// slaves. The select is latched at setup so it is stable for the whole transfer.
// An unmapped select gets a decode error. A stalled slave is aborted with an
// error after TIMEOUT wait cycles.
module apb4_mdd_router #(
  parameter int NUM_SLV = 4,
  parameter int SEL_W   = 5,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic [AW-1:0]             slv_apb_paddr_i,
  input  logic [2:0]                slv_apb_pprot_i,
  input  logic                      slv_apb_psel_i,
  input  logic                      slv_apb_penable_i,
  input  logic                      slv_apb_pwrite_i,
  input  logic [DW-1:0]             slv_apb_pwdata_i,
  input  logic [DW/8-1:0]           slv_apb_pstrb_i,
  output logic                      slv_apb_pready_o,
  output logic [DW-1:0]             slv_apb_prdata_o,
  output logic                      slv_apb_pslverr_o,
  output logic [NUM_SLV*AW-1:0]     mst_apb_paddr_o,
  output logic [NUM_SLV*3-1:0]      mst_apb_pprot_o,
  output logic [NUM_SLV-1:0]        mst_apb_psel_o,
  output logic [NUM_SLV-1:0]        mst_apb_penable_o,
  output logic [NUM_SLV-1:0]        mst_apb_pwrite_o,
  output logic [NUM_SLV*DW-1:0]     mst_apb_pwdata_o,
  output logic [NUM_SLV*DW/8-1:0]   mst_apb_pstrb_o,
  input  logic [NUM_SLV-1:0]        mst_apb_pready_i,
  input  logic [NUM_SLV*DW-1:0]     mst_apb_prdata_i,
  input  logic [NUM_SLV-1:0]        mst_apb_pslverr_i,
  output logic [SEL_W-1:0]          cur_sel_o,
  output logic                      tmo_o
);

  localparam int SW    = DW / 8;
  localparam bit TMO_EN = (TIMEOUT > 0);
  // A zero TIMEOUT still needs a one-bit counter; it is simply held at 0.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(TIMEOUT);
  localparam logic [SEL_W:0]   NUM_SLV_W = (SEL_W + 1)'(NUM_SLV);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  wait_cnt_q;

  logic [SEL_W-1:0]  route_sel;
  logic              sel_mapped;
  logic              route_en;
  logic              tmo_hit;
  logic              sel_pready;
  logic              sel_pslverr;
  logic [DW-1:0]     sel_prdata;

  // Setup cycle routes on the live select (zero latency); access uses the latched one.
  assign route_sel  = (state_q == ACCESS) ? sel_q : sel_i;
  assign sel_mapped = ({1'b0, route_sel} < NUM_SLV_W);
  // Reset gating keeps every output at 0 while rst_n_i is low, even if psel_i is high.
  assign route_en   = rst_n_i & slv_apb_psel_i & sel_mapped;
  assign tmo_hit    = TMO_EN && (wait_cnt_q == TMO_MAX);
  assign cur_sel_o  = sel_q;

  // Only the addressed slice carries the upstream request; all others stay 0.
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slice
    logic slice_hit;
    assign slice_hit = route_en && (route_sel == SEL_W'(gi));
    assign mst_apb_paddr_o[gi*AW +: AW]   = slice_hit ? slv_apb_paddr_i  : '0;
    assign mst_apb_pprot_o[gi*3 +: 3]     = slice_hit ? slv_apb_pprot_i  : '0;
    assign mst_apb_psel_o[gi]             = slice_hit;
    assign mst_apb_penable_o[gi]          = slice_hit & slv_apb_penable_i;
    assign mst_apb_pwrite_o[gi]           = slice_hit & slv_apb_pwrite_i;
    assign mst_apb_pwdata_o[gi*DW +: DW]  = slice_hit ? slv_apb_pwdata_i : '0;
    assign mst_apb_pstrb_o[gi*SW +: SW]   = slice_hit ? slv_apb_pstrb_i  : '0;
  end

  // Pick the response of the currently routed slave.
  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (route_sel == SEL_W'(i)) begin
        sel_pready  = mst_apb_pready_i[i];
        sel_pslverr = mst_apb_pslverr_i[i];
        sel_prdata  = mst_apb_prdata_i[i*DW +: DW];
      end
    end
  end

  // Upstream response: decode error, slave response (wins over timeout), or forced abort.
  always_comb begin
    slv_apb_pready_o  = 1'b0;
    slv_apb_pslverr_o = 1'b0;
    slv_apb_prdata_o  = '0;
    tmo_o             = 1'b0;
    if (rst_n_i && slv_apb_psel_i) begin
      if (state_q == ACCESS) begin
        if (!sel_mapped) begin
          slv_apb_pready_o  = 1'b1;
          slv_apb_pslverr_o = 1'b1;
        end else if (sel_pready) begin
          slv_apb_pready_o  = 1'b1;
          slv_apb_pslverr_o = sel_pslverr;
          slv_apb_prdata_o  = sel_prdata;
        end else if (tmo_hit) begin
          slv_apb_pready_o  = 1'b1;
          slv_apb_pslverr_o = 1'b1;
          tmo_o             = 1'b1;
        end else begin
          slv_apb_prdata_o  = sel_prdata;
        end
      end else if (sel_mapped) begin
        slv_apb_pready_o  = sel_pready;
        slv_apb_pslverr_o = sel_pslverr;
        slv_apb_prdata_o  = sel_prdata;
      end
    end
  end

  // Transfer FSM: latch select at setup, count access wait cycles, leave on completion or psel drop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (slv_apb_psel_i) begin
            sel_q   <= sel_i;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!slv_apb_psel_i || slv_apb_pready_o) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else if (TMO_EN && (wait_cnt_q != TMO_MAX)) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule
